// File: rtl/seq_shift_add_multiplier_if.sv
// Request/response bundle for the shift-and-add multiplier.
// Latency: none; the bundle is wiring only.
// Backpressure: start is taken only while busy is low; there is no queuing.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Requester side: drives operands and start, observes status and result.
  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  // Multiplier side.
  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
// Latency: start at edge E0 gives done after edge E(N+1); N = WIDTH, or fewer with early exit.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module seq_shift_add_multiplier #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_EN  = 1'b1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  seq_shift_add_multiplier_if.slave  mul
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     product_q;
  logic [PW-1:0]     acc_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplr_q;
  logic [CW-1:0]     iter_q;
  logic              neg_q;

  logic              mode_d;
  logic [WIDTH-1:0]  a_mag_d;
  logic [WIDTH-1:0]  b_mag_d;
  logic              neg_d;
  logic [PW-1:0]     addend_d;
  logic [PW-1:0]     acc_d;
  logic [WIDTH-1:0]  mplr_d;
  logic              last_d;

  // Operand conditioning at the start edge: magnitudes plus the result sign.
  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mode_d  = mul.signed_mode & SIGNED_EN;
    a_mag_d = (mode_d && mul.a[WIDTH-1]) ? (~mul.a + 1'b1) : mul.a;
    b_mag_d = (mode_d && mul.b[WIDTH-1]) ? (~mul.b + 1'b1) : mul.b;
    neg_d   = mode_d & (mul.a[WIDTH-1] ^ mul.b[WIDTH-1]);
  end

  // One iteration: conditionally add the shifted multiplicand, retire one multiplier bit.
  // Early exit fires when no set bits remain, so at least one iteration always runs.
  always_comb begin
    addend_d = {{WIDTH{1'b0}}, mcand_q} << iter_q;
    acc_d    = mplr_q[0] ? (acc_q + addend_d) : acc_q;
    mplr_d   = mplr_q >> 1;
    last_d   = (iter_q == ITER_LAST) || (EARLY_EXIT && (mplr_d == '0));
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul.start) begin
            mcand_q <= a_mag_d;
            mplr_q  <= b_mag_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          iter_q <= iter_q + CW'(1);
          if (last_d) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          // A zero magnitude negates to zero, so no negative zero can appear.
          product_q <= neg_q ? (~acc_q + 1'b1) : acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mul.busy    = busy_q;
  assign mul.done    = done_q;
  assign mul.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance 0: defaults. Instance 1: EARLY_EXIT=0. Instance 2: SIGNED_EN=0.
  seq_shift_add_multiplier_if #(.WIDTH(W)) if0 ();
  seq_shift_add_multiplier_if #(.WIDTH(W)) if1 ();
  seq_shift_add_multiplier_if #(.WIDTH(W)) if2 ();

  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .mul(if0));
  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .mul(if1));
  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .mul(if2));

  logic         start_s [3];
  logic         sm_s    [3];
  logic [W-1:0] a_s     [3];
  logic [W-1:0] b_s     [3];
  logic         busy_w  [3];
  logic         done_w  [3];
  logic [2*W-1:0] prod_w [3];

  assign if0.start = start_s[0]; assign if0.signed_mode = sm_s[0];
  assign if0.a = a_s[0];         assign if0.b = b_s[0];
  assign if1.start = start_s[1]; assign if1.signed_mode = sm_s[1];
  assign if1.a = a_s[1];         assign if1.b = b_s[1];
  assign if2.start = start_s[2]; assign if2.signed_mode = sm_s[2];
  assign if2.a = a_s[2];         assign if2.b = b_s[2];
  assign busy_w[0] = if0.busy; assign done_w[0] = if0.done; assign prod_w[0] = if0.product;
  assign busy_w[1] = if1.busy; assign done_w[1] = if1.done; assign prod_w[1] = if1.product;
  assign busy_w[2] = if2.busy; assign done_w[2] = if2.done; assign prod_w[2] = if2.product;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic bit is_signed(int sel, logic sm);
    return sm && (sel != 2);
  endfunction

  function automatic int as_int(logic [W-1:0] v, bit sgn);
    return (sgn && v[W-1]) ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic int exp_iters(int sel, logic [W-1:0] b, logic sm);
    int mag;
    int n;
    if (sel == 1) return W;
    mag = as_int(b, is_signed(sel, sm));
    if (mag < 0) mag = -mag;
    if (mag == 0) return 1;
    n = 0;
    while (mag > 0) begin
      n++;
      mag = mag / 2;
    end
    return n;
  endfunction

  function automatic logic [2*W-1:0] exp_prod(int sel, logic [W-1:0] a, logic [W-1:0] b, logic sm);
    int x;
    int y;
    x = as_int(a, is_signed(sel, sm));
    y = as_int(b, is_signed(sel, sm));
    return (2*W)'(x * y);
  endfunction

  // Presents a request for one edge (the E0 edge), then drops start.
  task automatic launch(int sel, logic [W-1:0] a, logic [W-1:0] b, logic sm);
    a_s[sel] = a;
    b_s[sel] = b;
    sm_s[sel] = sm;
    start_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_s[sel] = 1'b0;
  endtask

  // Counts edges until done, checks latency, product and busy; optionally checks the cycle after done.
  task automatic wait_done(int sel, int exp_edges, logic [2*W-1:0] exp_p, string nm, bit chk_after);
    int got;
    bit busy_ok;
    got = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy_w[sel] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (done_w[sel] === 1'b1) begin
        got = k;
        break;
      end
    end
    total_cnt++;
    if (got == exp_edges) pass_cnt++;
    else $display("FAIL %s latency: done after %0d edges, expected %0d", nm, got, exp_edges);
    total_cnt++;
    if (prod_w[sel] === exp_p && busy_w[sel] === 1'b0) pass_cnt++;
    else $display("FAIL %s product: got 0x%h busy=%b, expected 0x%h busy=0", nm, prod_w[sel], busy_w[sel], exp_p);
    total_cnt++;
    if (busy_ok) pass_cnt++;
    else $display("FAIL %s busy: busy dropped before done, expected high throughout", nm);
    if (chk_after) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (done_w[sel] === 1'b0 && busy_w[sel] === 1'b0 && prod_w[sel] === exp_p) pass_cnt++;
      else $display("FAIL %s hold: done=%b busy=%b product=0x%h, expected done=0 busy=0 product=0x%h",
                    nm, done_w[sel], busy_w[sel], prod_w[sel], exp_p);
    end
  endtask

  task automatic check_zero(string nm);
    for (int s = 0; s < 3; s++) begin
      total_cnt++;
      if (busy_w[s] === 1'b0 && done_w[s] === 1'b0 && prod_w[s] === '0) pass_cnt++;
      else $display("FAIL %s inst%0d: busy=%b done=%b product=0x%h, expected all 0",
                    nm, s, busy_w[s], done_w[s], prod_w[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    launch(0, 8'd8, 8'd5, 1'b0);
    wait_done(0, 4, 16'h0028, "u_8x5", 1'b1);
    launch(0, 8'd255, 8'd255, 1'b0);
    wait_done(0, 9, 16'hFE01, "u_255x255", 1'b1);
    launch(1, 8'd255, 8'd5, 1'b0);
    wait_done(1, 9, 16'd1275, "u_noexit_255x5", 1'b1);
  endtask

  task automatic test_signed();
    launch(0, 8'hF9, 8'd6, 1'b1);
    wait_done(0, 4, 16'hFFD6, "s_m7x6", 1'b1);
    launch(0, 8'h80, 8'h80, 1'b1);
    wait_done(0, 9, 16'h4000, "s_m128xm128", 1'b1);
    launch(0, 8'h80, 8'h7F, 1'b1);
    wait_done(0, 8, 16'hC080, "s_m128x127", 1'b1);
    launch(2, 8'hF9, 8'd6, 1'b1);
    wait_done(2, 4, 16'd1494, "nosign_249x6", 1'b1);
  endtask

  task automatic test_zero();
    launch(0, 8'd200, 8'd0, 1'b0);
    wait_done(0, 2, 16'h0000, "z_200x0", 1'b1);
    launch(0, 8'hFB, 8'd0, 1'b1);
    wait_done(0, 2, 16'h0000, "z_m5x0", 1'b1);
    launch(0, 8'd0, 8'hFD, 1'b1);
    wait_done(0, 3, 16'h0000, "z_0xm3", 1'b1);
    launch(1, 8'hFB, 8'd0, 1'b1);
    wait_done(1, 9, 16'h0000, "z_noexit_m5x0", 1'b1);
  endtask

  task automatic test_busy_ignore();
    int extra;
    launch(0, 8'd10, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    a_s[0] = 8'd7;
    b_s[0] = 8'd8;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    wait_done(0, 2, 16'd50, "busy_ignore", 1'b1);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) extra++;
    end
    total_cnt++;
    if (extra == 0 && prod_w[0] === 16'd50) pass_cnt++;
    else $display("FAIL busy_ignore queued: %0d active cycles, product=0x%h, expected 0 and 0x0032",
                  extra, prod_w[0]);
  endtask

  task automatic test_back_to_back();
    launch(0, 8'd10, 8'd5, 1'b0);
    wait_done(0, 4, 16'd50, "b2b_first", 1'b0);
    launch(0, 8'd7, 8'd8, 1'b0);
    wait_done(0, 5, 16'd56, "b2b_second", 1'b1);
  endtask

  task automatic test_reset_abort();
    int stale;
    launch(0, 8'd255, 8'd255, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("abort_async");
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) stale++;
    end
    total_cnt++;
    if (stale == 0) pass_cnt++;
    else $display("FAIL abort_stale: %0d active cycles after reset, expected 0", stale);
    launch(0, 8'd7, 8'd6, 1'b0);
    wait_done(0, 4, 16'd42, "abort_recover", 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 30; n++) begin
        case ($urandom_range(0, 5))
          0: ra = 8'h80;
          1: ra = 8'h00;
          default: ra = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 5))
          0: rb = 8'h80;
          1: rb = 8'hFF;
          default: rb = 8'($urandom_range(0, 255));
        endcase
        rs = 1'($urandom_range(0, 1));
        launch(s, ra, rb, rs);
        wait_done(s, exp_iters(s, rb, rs) + 1, exp_prod(s, ra, rb, rs), "random", n[0]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      start_s[s] = 1'b0;
      sm_s[s] = 1'b0;
      a_s[s] = '0;
      b_s[s] = '0;
    end
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
